fp_div_seq: RTL

Sequential IEEE-754 single-precision divider: q = a / b. Companion to the combinational multiplier in the FP execute stage. Iterates one quotient bit per clock using radix-2 restoring division and rounds to nearest, ties to even. Has a start/busy/valid handshake so the FPU control can stall on long-latency divides.

---
 rtl/fp_div_seq_if.sv | 21 ++
 rtl/fp_div_seq.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_div_seq_if.sv
// Request/response bundle for fp_div_seq. The fflags member exists only when
// FP_DIV_FFLAGS_EN is defined.
interface fp_div_seq_if #(
    parameter int unsigned W = 32
);
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic         valid;
    logic         busy;
`ifdef FP_DIV_FFLAGS_EN
    logic [4:0]   fflags;

    modport master (output start, a, b, input q, valid, busy, fflags);
    modport slave  (input start, a, b, output q, valid, busy, fflags);
`else
    modport master (output start, a, b, input q, valid, busy);
    modport slave  (input start, a, b, output q, valid, busy);
`endif
endinterface

// File: rtl/fp_div_seq.sv
// Sequential single-precision divider: radix-2 restoring, one quotient bit per clock, RNE rounding.
// Optional exception flags ({NV,DZ,OF,UF,NX}) are enabled by defining FP_DIV_FFLAGS_EN.
module fp_div_seq #(
    parameter int unsigned NEXP = 8,
    parameter int unsigned NSIG = 23,
    parameter int          BIAS = 127
) (
    input  logic        clk,
    input  logic        rst_n,
    fp_div_seq_if.slave bus
);
    localparam int unsigned W  = NEXP + NSIG + 1;
    localparam int unsigned SW = NSIG + 1;
    localparam int unsigned RW = NSIG + 2;
    localparam int unsigned QW = NSIG + 3;
    localparam int unsigned EW = NEXP + 2;
    localparam int unsigned CW = $clog2(QW);
    localparam logic signed [EW-1:0] EMAX  = EW'(BIAS);
    localparam logic signed [EW-1:0] EMIN  = EW'(1 - BIAS);
    localparam logic signed [EW-1:0] ETINY = EW'(1 - BIAS - int'(NSIG));
    localparam logic [CW-1:0]        CNT_LAST = CW'(QW - 1);

    typedef enum logic [1:0] {StIdle, StCalc, StRound, StDone} state_e;

    state_e                 state_q, state_d;
    logic                   busy;
    logic                   sign_q;
    logic signed [EW-1:0]   e_q;
    logic [RW-1:0]          r_q;
    logic [SW-1:0]          d_q;
    logic [QW-1:0]          quo_q;
    logic [CW-1:0]          cnt_q;
    logic [W-1:0]           res_q;
    logic [W-1:0]           q_q;
    logic                   valid_q;

    // Subnormal operands read as zero: exponent field 0 is the only zero test.
    logic [NEXP-1:0] a_exp, b_exp;
    logic [NSIG-1:0] a_frac, b_frac;
    logic            a_zero, a_inf, a_nan, a_snan;
    logic            b_zero, b_inf, b_nan, b_snan;
    logic            sign_in;

    assign a_exp   = bus.a[NSIG +: NEXP];
    assign b_exp   = bus.b[NSIG +: NEXP];
    assign a_frac  = bus.a[NSIG-1:0];
    assign b_frac  = bus.b[NSIG-1:0];
    assign a_zero  = (a_exp == '0);
    assign b_zero  = (b_exp == '0);
    assign a_inf   = (&a_exp) && (a_frac == '0);
    assign b_inf   = (&b_exp) && (b_frac == '0);
    assign a_nan   = (&a_exp) && (a_frac != '0);
    assign b_nan   = (&b_exp) && (b_frac != '0);
    assign a_snan  = a_nan && !a_frac[NSIG-1];
    assign b_snan  = b_nan && !b_frac[NSIG-1];
    assign sign_in = bus.a[W-1] ^ bus.b[W-1];

    logic         special;
    logic [W-1:0] spec_res;

    always_comb begin
        special  = 1'b1;
        spec_res = '0;
        if (a_snan) begin
            spec_res = bus.a;
        end else if (b_snan) begin
            spec_res = bus.b;
        end else if (a_nan) begin
            spec_res = bus.a;
        end else if (b_nan) begin
            spec_res = bus.b;
        end else if ((a_inf && b_inf) || (a_zero && b_zero)) begin
            spec_res = {1'b0, {NEXP{1'b1}}, 1'b1, {(NSIG-1){1'b0}}};
        end else if (a_inf || b_zero) begin
            spec_res = {sign_in, {NEXP{1'b1}}, {NSIG{1'b0}}};
        end else if (a_zero || b_inf) begin
            spec_res = {sign_in, {(W-1){1'b0}}};
        end else begin
            special = 1'b0;
        end
    end

    logic          ge;
    logic [RW-1:0] r_sub, r_next;

    assign ge     = (r_q >= {1'b0, d_q});
    assign r_sub  = ge ? (r_q - {1'b0, d_q}) : r_q;
    assign r_next = r_sub << 1;

    logic [SW-1:0]        sig, sig_r;
    logic [SW:0]          sig_inc;
    logic                 guard, sticky;
    logic signed [EW-1:0] e_n, e_r;
    logic [EW-1:0]        sh;
    logic [W-1:0]         rnd_res;

    always_comb begin
        if (quo_q[QW-1]) begin
            sig    = quo_q[QW-1:2];
            guard  = quo_q[1];
            sticky = quo_q[0] | (|r_q);
            e_n    = e_q;
        end else begin
            sig    = quo_q[QW-2:1];
            guard  = quo_q[0];
            sticky = |r_q;
            e_n    = e_q - EW'(1);
        end
        sig_inc = {1'b0, sig} + {{SW{1'b0}}, guard & (sticky | sig[0])};
        if (sig_inc[SW]) begin
            sig_r = {1'b1, {NSIG{1'b0}}};
            e_r   = e_n + EW'(1);
        end else begin
            sig_r = sig_inc[SW-1:0];
            e_r   = e_n;
        end
        sh = EW'(EMIN - e_r);
        // Subnormal results truncate the already-rounded significand.
        if (e_r > EMAX) begin
            rnd_res = {sign_q, {NEXP{1'b1}}, {NSIG{1'b0}}};
        end else if (e_r < ETINY) begin
            rnd_res = {sign_q, {(W-1){1'b0}}};
        end else if (e_r < EMIN) begin
            rnd_res = {sign_q, {NEXP{1'b0}}, NSIG'(sig_r >> sh)};
        end else begin
            rnd_res = {sign_q, NEXP'(e_r + EMAX), sig_r[NSIG-1:0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.start) state_d = special ? StDone : StCalc;
            StCalc:  if (cnt_q == CNT_LAST) state_d = StRound;
            StRound: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = (state_q != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q  <= 1'b0;
            e_q     <= '0;
            r_q     <= '0;
            d_q     <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            q_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        sign_q <= sign_in;
                        e_q    <= EW'(a_exp) - EW'(b_exp);
                        r_q    <= {2'b01, a_frac};
                        d_q    <= {1'b1, b_frac};
                        quo_q  <= '0;
                        cnt_q  <= '0;
                        res_q  <= spec_res;
                    end
                end
                StCalc: begin
                    r_q   <= r_next;
                    quo_q <= {quo_q[QW-2:0], ge};
                    cnt_q <= cnt_q + 1'b1;
                end
                StRound: res_q <= rnd_res;
                StDone: begin
                    q_q     <= res_q;
                    valid_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.q     = q_q;
    assign bus.valid = valid_q;
    assign bus.busy  = busy;

`ifdef FP_DIV_FFLAGS_EN
    logic [4:0] spec_fl, rnd_fl, res_fl_q, fflags_q;
    logic       lost;

    always_comb begin
        spec_fl    = '0;
        spec_fl[4] = a_snan | b_snan |
                     (!a_nan && !b_nan && ((a_inf && b_inf) || (a_zero && b_zero)));
        spec_fl[3] = !a_nan && !b_nan && !a_inf && !a_zero && b_zero;
    end

    always_comb begin
        lost   = |(sig_r & ~({SW{1'b1}} << sh));
        rnd_fl = '0;
        if (e_r > EMAX) begin
            rnd_fl = 5'b00101;
        end else if (e_r < ETINY) begin
            rnd_fl = 5'b00011;
        end else if (e_r < EMIN) begin
            if (guard | sticky | lost) rnd_fl = 5'b00011;
        end else begin
            rnd_fl[0] = guard | sticky;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_fl_q <= '0;
            fflags_q <= '0;
        end else if (state_q == StIdle && bus.start) begin
            res_fl_q <= spec_fl;
            fflags_q <= '0;
        end else if (state_q == StRound) begin
            res_fl_q <= rnd_fl;
        end else if (state_q == StDone) begin
            fflags_q <= res_fl_q;
        end
    end

    assign bus.fflags = fflags_q;
`endif
endmodule
